fpu_prog_sequencer: RTL and testbench

// Parametrised program loader + instruction sequencer for the FPU test core. Packs a UART byte

---
 rtl/fpu_seq_pkg.sv | 7 +
 rtl/fpu_byte_packer.sv | 54 +++++
 rtl/fpu_prog_sequencer.sv | 145 ++++++++++++++
 tb/tb_fpu_prog_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FPU program loader / instruction sequencer.
package fpu_seq_pkg;
    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE, S_ERR} state_t;

    localparam int          PC_W         = 32;
    localparam logic [31:0] END_WORD_DEF = 32'h0000_0FFF;
endpackage

// File: rtl/fpu_byte_packer.sv
// Assembles little-endian bytes into DATA_W-bit words; drops a partial word after TIMEOUT idle cycles.
module fpu_byte_packer #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    output logic [DATA_W-1:0] word,
    output logic              word_vld
);
    localparam int BYTES = DATA_W / 8;
    localparam int K_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int T_W   = $clog2(TIMEOUT + 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(BYTES - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT - 1);

    logic [K_W-1:0]    k;
    logic [T_W-1:0]    idle;
    logic [DATA_W-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k    <= '0;
            idle <= '0;
        end else if (rx_dv) begin
            idle <= '0;
            k    <= (k == K_LAST) ? '0 : k + 1'b1;
        end else if (k != '0) begin
            if (idle == T_LAST) begin
                k    <= '0;
                idle <= '0;
            end else begin
                idle <= idle + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_dv)
            acc[int'(k)*8 +: 8] <= rx_byte;
    end

    // The completing byte is merged combinationally so the word is usable in its arrival cycle.
    always_comb begin
        word = acc;
        for (int j = 0; j < BYTES; j++)
            if (K_W'(j) == k)
                word[8*j +: 8] = rx_byte;
    end

    assign word_vld = rx_dv && (k == K_LAST);
endmodule

// File: rtl/fpu_prog_sequencer.sv
// Program loader + sequencer: writes packed UART words to SRAM, then replays them to the decoder.
module fpu_prog_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                MEM_LAT  = 1,
    parameter logic [DATA_W-1:0] END_WORD = DATA_W'(END_WORD_DEF),
    parameter int                TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [PC_W-1:0]   inst_pc_o,
    output logic              active_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              overflow_o
);
    localparam int              BYTES = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t             state;
    logic [DATA_W-1:0]  pk_word;
    logic               pk_vld;
    logic               pk_dv;
    logic [ADDR_W-1:0]  wptr;
    logic [ADDR_W-1:0]  wp_base;
    logic [ADDR_W:0]    wc_base;
    logic [ADDR_W:0]    raddr;
    logic               need_rd;
    logic               issue;
    logic               accept;
    logic               last;
    logic [MEM_LAT-1:0] pend;

    assign pk_dv = rx_dv_i && (state != S_RUN);

    fpu_byte_packer #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .rx_dv    (pk_dv),
        .rx_byte  (rx_byte_i),
        .word     (pk_word),
        .word_vld (pk_vld)
    );

    // A byte arriving in DONE/ERR starts a fresh load, so counters are seen as zero for it.
    assign wp_base = (state == S_LOAD) ? wptr : '0;
    assign wc_base = (state == S_LOAD) ? word_cnt_o : '0;

    // Reads issue in the acceptance cycle itself to sustain one word per MEM_LAT+1 cycles.
    assign accept      = inst_valid_o && inst_ready_i;
    assign last        = (raddr == word_cnt_o);
    assign issue       = (state == S_RUN) && (need_rd || (accept && !last));
    assign mem_re_o    = issue;
    assign mem_raddr_o = raddr[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_LOAD;
            wptr         <= '0;
            raddr        <= '0;
            need_rd      <= 1'b0;
            pend         <= '0;
            mem_we_o     <= 1'b0;
            mem_waddr_o  <= '0;
            mem_wdata_o  <= '0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            active_o     <= 1'b0;
            load_done_o  <= 1'b0;
            word_cnt_o   <= '0;
            overflow_o   <= 1'b0;
        end else begin
            mem_we_o    <= 1'b0;
            load_done_o <= 1'b0;
            pend[0]     <= issue;
            for (int i = 1; i < MEM_LAT; i++)
                pend[i] <= pend[i-1];

            case (state)
                S_RUN: begin
                    if (issue) begin
                        need_rd <= 1'b0;
                        raddr   <= raddr + 1'b1;
                    end
                    if (pend[MEM_LAT-1]) begin
                        inst_o       <= mem_rdata_i;
                        inst_valid_o <= 1'b1;
                        inst_pc_o    <= PC_W'(raddr - 1'b1) * PC_W'(BYTES);
                    end
                    if (accept) begin
                        inst_valid_o <= 1'b0;
                        if (last) begin
                            active_o <= 1'b0;
                            state    <= S_DONE;
                        end
                    end
                end
                default: begin
                    if (state != S_LOAD && rx_dv_i) begin
                        state      <= S_LOAD;
                        overflow_o <= 1'b0;
                        wptr       <= '0;
                        word_cnt_o <= '0;
                    end
                    if (pk_vld) begin
                        if (pk_word == END_WORD) begin
                            load_done_o <= 1'b1;
                            if (wc_base == '0) begin
                                state <= S_DONE;
                            end else begin
                                state    <= S_RUN;
                                active_o <= 1'b1;
                                raddr    <= '0;
                                need_rd  <= 1'b1;
                            end
                        end else if (wc_base == DEPTH) begin
                            overflow_o <= 1'b1;
                            state      <= S_ERR;
                        end else begin
                            mem_we_o    <= 1'b1;
                            mem_waddr_o <= wp_base;
                            mem_wdata_o <= pk_word;
                            wptr        <= wp_base + 1'b1;
                            word_cnt_o  <= wc_base + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_prog_sequencer.sv
// Directed bench: instance A uses default parameters, instance B uses ADDR_W=2, MEM_LAT=3, TIMEOUT=16.
module tb_fpu_prog_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] ENDW = 32'h0000_0FFF;
    localparam int          NV   = 3;

    typedef struct packed {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] word;
        logic [7:0]  addr;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs [NV];

    int nvec = 0;
    int nerr = 0;

    // ---------------- instance A ----------------
    logic        rst_a, dv_a, we_a, re_a, iv_a, ir_a, act_a, done_a, ov_a;
    logic [7:0]  byte_a, waddr_a, raddr_a;
    logic [31:0] wdata_a, rdata_a, inst_a, pc_a, pipe_a;
    logic [8:0]  wc_a;
    logic [31:0] mem_a [256];

    fpu_prog_sequencer u_a (
        .clk(clk), .rst(rst_a), .rx_dv_i(dv_a), .rx_byte_i(byte_a),
        .mem_we_o(we_a), .mem_waddr_o(waddr_a), .mem_wdata_o(wdata_a),
        .mem_re_o(re_a), .mem_raddr_o(raddr_a), .mem_rdata_i(rdata_a),
        .inst_valid_o(iv_a), .inst_ready_i(ir_a), .inst_o(inst_a), .inst_pc_o(pc_a),
        .active_o(act_a), .load_done_o(done_a), .word_cnt_o(wc_a), .overflow_o(ov_a)
    );

    always @(posedge clk) begin
        if (we_a) mem_a[waddr_a] <= wdata_a;
        pipe_a <= mem_a[raddr_a];
    end
    assign rdata_a = pipe_a;

    // ---------------- instance B ----------------
    logic        rst_b, dv_b, we_b, re_b, iv_b, ir_b, act_b, done_b, ov_b;
    logic [7:0]  byte_b;
    logic [1:0]  waddr_b, raddr_b;
    logic [31:0] wdata_b, rdata_b, inst_b, pc_b;
    logic [2:0]  wc_b;
    logic [31:0] mem_b [4];
    logic [31:0] pipe_b [3];

    fpu_prog_sequencer #(.ADDR_W(2), .MEM_LAT(3), .TIMEOUT(16)) u_b (
        .clk(clk), .rst(rst_b), .rx_dv_i(dv_b), .rx_byte_i(byte_b),
        .mem_we_o(we_b), .mem_waddr_o(waddr_b), .mem_wdata_o(wdata_b),
        .mem_re_o(re_b), .mem_raddr_o(raddr_b), .mem_rdata_i(rdata_b),
        .inst_valid_o(iv_b), .inst_ready_i(ir_b), .inst_o(inst_b), .inst_pc_o(pc_b),
        .active_o(act_b), .load_done_o(done_b), .word_cnt_o(wc_b), .overflow_o(ov_b)
    );

    always @(posedge clk) begin
        if (we_b) mem_b[waddr_b] <= wdata_b;
        pipe_b[0] <= mem_b[raddr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rdata_b = pipe_b[2];

    // ---------------- event logs ----------------
    logic [31:0] wl_addr_a[$], wl_data_a[$], il_pc_a[$], il_inst_a[$];
    logic [31:0] wl_addr_b[$], wl_data_b[$], il_pc_b[$], il_inst_b[$];
    int re_cnt_a, iv_cnt_a, done_cnt_a, both_a;
    int re_cnt_b, done_cnt_b, both_b;

    always @(negedge clk) begin
        if (we_a) begin wl_addr_a.push_back(32'(waddr_a)); wl_data_a.push_back(wdata_a); end
        if (re_a) re_cnt_a++;
        if (iv_a) iv_cnt_a++;
        if (iv_a && ir_a) begin il_pc_a.push_back(pc_a); il_inst_a.push_back(inst_a); end
        if (done_a) done_cnt_a++;
        if (we_a && re_a) both_a++;
        if (we_b) begin wl_addr_b.push_back(32'(waddr_b)); wl_data_b.push_back(wdata_b); end
        if (re_b) re_cnt_b++;
        if (iv_b && ir_b) begin il_pc_b.push_back(pc_b); il_inst_b.push_back(inst_b); end
        if (done_b) done_cnt_b++;
        if (we_b && re_b) both_b++;
    end

    task automatic clear_logs();
        wl_addr_a.delete(); wl_data_a.delete(); il_pc_a.delete(); il_inst_a.delete();
        wl_addr_b.delete(); wl_data_b.delete(); il_pc_b.delete(); il_inst_b.delete();
        re_cnt_a = 0; iv_cnt_a = 0; done_cnt_a = 0; both_a = 0;
        re_cnt_b = 0; done_cnt_b = 0; both_b = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] b);
        @(posedge clk); #1; dv_a = 1'b1; byte_a = b;
        @(posedge clk); #1; dv_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        @(posedge clk); #1; dv_b = 1'b1; byte_b = b;
        @(posedge clk); #1; dv_b = 1'b0;
    endtask

    task automatic word_a(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_a(w[8*i +: 8]);
    endtask

    task automatic word_b(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_b(w[8*i +: 8]);
    endtask

    task automatic load_vecs_a();
        for (int i = 0; i < NV; i++) begin
            send_a(vecs[i].b0); send_a(vecs[i].b1); send_a(vecs[i].b2); send_a(vecs[i].b3);
        end
        send_a(8'hFF); send_a(8'h0F); send_a(8'h00); send_a(8'h00);
    endtask

    task automatic check_prog_a();
        check("wr_count", 64'(wl_addr_a.size()), 64'(NV));
        check("inst_count", 64'(il_pc_a.size()), 64'(NV));
        for (int i = 0; i < NV; i++) begin
            if (i < wl_addr_a.size()) begin
                check($sformatf("wr_addr[%0d]", i), wl_addr_a[i], 64'(vecs[i].addr));
                check($sformatf("wr_data[%0d]", i), wl_data_a[i], vecs[i].word);
            end
            if (i < il_pc_a.size()) begin
                check($sformatf("inst_pc[%0d]", i), il_pc_a[i], vecs[i].pc);
                check($sformatf("inst[%0d]", i), il_inst_a[i], vecs[i].word);
            end
        end
    endtask

    task automatic wait_iv_a(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (iv_a) begin ok = 1'b1; break; end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_iv_b(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (iv_b) begin ok = 1'b1; break; end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int re_snap;
        vecs[0] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 32'hA1B2_C3D4, 8'd0, 32'd0};
        vecs[1] = '{8'h01, 8'h00, 8'h00, 8'h00, 32'h0000_0001, 8'd1, 32'd4};
        vecs[2] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF, 8'd2, 32'd8};

        rst_a = 1'b1; dv_a = 1'b0; byte_a = '0; ir_a = 1'b1;
        rst_b = 1'b1; dv_b = 1'b0; byte_b = '0; ir_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 64'(we_a), 0);
        check("rst_re", 64'(re_a), 0);
        check("rst_valid", 64'(iv_a), 0);
        check("rst_active", 64'(act_a), 0);
        check("rst_done", 64'(done_a), 0);
        check("rst_wcnt", 64'(wc_a), 0);
        check("rst_ovf", 64'(ov_a), 0);
        check("rst_pc", 64'(pc_a), 0);
        check("rst_inst", 64'(inst_a), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        clear_logs();

        // Three-word program, free-running decoder
        load_vecs_a();
        repeat (30) @(posedge clk);
        #1;
        check_prog_a();
        check("t1_done_pulses", 64'(done_cnt_a), 1);
        check("t1_reads", 64'(re_cnt_a), 3);
        check("t1_wcnt", 64'(wc_a), 3);
        check("t1_active", 64'(act_a), 0);
        check("t1_valid", 64'(iv_a), 0);
        check("t1_we_re_overlap", 64'(both_a), 0);

        // Empty program: END_WORD only
        clear_logs();
        word_a(ENDW);
        repeat (20) @(posedge clk);
        #1;
        check("t2_wcnt", 64'(wc_a), 0);
        check("t2_done_pulses", 64'(done_cnt_a), 1);
        check("t2_reads", 64'(re_cnt_a), 0);
        check("t2_valid_cycles", 64'(iv_cnt_a), 0);
        check("t2_writes", 64'(wl_addr_a.size()), 0);
        check("t2_active", 64'(act_a), 0);

        // Decoder stall on word 1
        clear_logs();
        ir_a = 1'b0;
        load_vecs_a();
        wait_iv_a("t3_wait_w0");
        check("t3_w0_pc", 64'(pc_a), 0);
        ir_a = 1'b1;
        @(posedge clk); #1;
        ir_a = 1'b0;
        wait_iv_a("t3_wait_w1");
        re_snap = re_cnt_a;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t3_hold_valid", 64'(iv_a), 1);
            check("t3_hold_pc", 64'(pc_a), 4);
            check("t3_hold_inst", 64'(inst_a), 32'h0000_0001);
        end
        check("t3_no_extra_read", 64'(re_cnt_a), 64'(re_snap));
        ir_a = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_prog_a();
        check("t3_reads", 64'(re_cnt_a), 3);
        check("t3_we_re_overlap", 64'(both_a), 0);

        // Partial word discarded by inter-byte timeout
        clear_logs();
        send_a(8'hAA); send_a(8'hBB);
        repeat (4100) @(posedge clk);
        word_a(32'h1234_5678);
        word_a(ENDW);
        repeat (20) @(posedge clk);
        #1;
        check("t4_writes", 64'(wl_addr_a.size()), 1);
        if (wl_addr_a.size() > 0) begin
            check("t4_wr_addr", wl_addr_a[0], 0);
            check("t4_wr_data", wl_data_a[0], 32'h1234_5678);
        end
        check("t4_insts", 64'(il_inst_a.size()), 1);
        if (il_inst_a.size() > 0) check("t4_inst", il_inst_a[0], 32'h1234_5678);
        check("t4_wcnt", 64'(wc_a), 1);

        // B: gap just below TIMEOUT keeps the partial word, then overflow on the 5th word
        clear_logs();
        send_b(8'h11); send_b(8'h22);
        repeat (14) @(posedge clk);
        send_b(8'h33); send_b(8'h44);
        word_b(32'hA0A0_A0A1);
        word_b(32'hA0A0_A0A2);
        word_b(32'hA0A0_A0A3);
        word_b(32'hA0A0_A0A4);
        repeat (5) @(posedge clk);
        #1;
        check("t5_writes", 64'(wl_addr_b.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < wl_addr_b.size())
                check($sformatf("t5_wr_addr[%0d]", i), wl_addr_b[i], 64'(i));
        if (wl_data_b.size() > 0) check("t5_gap_word", wl_data_b[0], 32'h4433_2211);
        if (wl_data_b.size() > 3) check("t5_last_word", wl_data_b[3], 32'hA0A0_A0A3);
        check("t5_ovf", 64'(ov_b), 1);
        check("t5_wcnt", 64'(wc_b), 4);
        check("t5_done_pulses", 64'(done_cnt_b), 0);
        check("t5_reads", 64'(re_cnt_b), 0);

        // Next byte leaves ERR and clears overflow; it is byte 0 of the new load
        send_b(8'h01);
        check("t6_ovf_clear", 64'(ov_b), 0);
        check("t6_wcnt_clear", 64'(wc_b), 0);
        send_b(8'h02); send_b(8'h03); send_b(8'h04);
        word_b(32'h5566_7788);
        ir_b = 1'b0;
        word_b(ENDW);
        wait_iv_b("t6_wait_w0");
        check("t6_inst", 64'(inst_b), 32'h0403_0201);
        check("t6_pc", 64'(pc_b), 0);
        check("t6_active", 64'(act_b), 1);

        // Asynchronous reset mid-RUN
        rst_b = 1'b1;
        #1;
        check("t7_valid", 64'(iv_b), 0);
        check("t7_active", 64'(act_b), 0);
        check("t7_inst", 64'(inst_b), 0);
        check("t7_pc", 64'(pc_b), 0);
        check("t7_re", 64'(re_b), 0);
        check("t7_raddr", 64'(raddr_b), 0);
        check("t7_wcnt", 64'(wc_b), 0);
        check("t7_we", 64'(we_b), 0);
        check("t7_ovf", 64'(ov_b), 0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        ir_b = 1'b1;
        clear_logs();
        word_b(32'h9ABC_DEF0);
        word_b(ENDW);
        repeat (30) @(posedge clk);
        #1;
        check("t8_writes", 64'(wl_addr_b.size()), 1);
        if (wl_addr_b.size() > 0) begin
            check("t8_wr_addr", wl_addr_b[0], 0);
            check("t8_wr_data", wl_data_b[0], 32'h9ABC_DEF0);
        end
        check("t8_insts", 64'(il_inst_b.size()), 1);
        if (il_inst_b.size() > 0) begin
            check("t8_inst", il_inst_b[0], 32'h9ABC_DEF0);
            check("t8_pc", il_pc_b[0], 0);
        end
        check("t8_reads", 64'(re_cnt_b), 1);
        check("t8_wcnt", 64'(wc_b), 1);
        check("t8_active", 64'(act_b), 0);
        check("t8_we_re_overlap", 64'(both_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
